// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver feeding a small circular byte FIFO.
// The receiver samples mid-bit and never stalls. A full FIFO drops the new byte
// and raises a sticky overflow flag. A low stop bit raises a sticky frame-error
// flag. After a low stop bit the receiver waits for the line to go high again.
module uart_rx_sink #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    input  logic       err_clr_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   FULL_BIT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   HALF_BIT  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    // receiver state
    logic          r_sync1, r_sync2, r_rx_prev;
    logic [1:0]    r_settle;
    state_t        r_state, w_state_next;
    logic [15:0]   r_cnt, w_cnt_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_push, w_push_next;
    logic          w_frame_set;
    logic          w_rx_s, w_fall, w_cnt_zero;

    // FIFO state
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
    logic [CW-1:0] r_count, w_occ_after_pop, w_count_next;
    logic [7:0]    r_head, w_head_next;
    logic          w_full, w_pop, w_wr_en, w_ovf_set;
    logic          r_frame_err, r_overflow;

    assign w_rx_s     = r_sync2;
    assign w_cnt_zero = (r_cnt == 16'd0);
    // Edges count only once the synchronizer and the history flop both hold real
    // line samples. The reset value of 1 is not a line sample. A line that stays
    // low through reset therefore cannot look like a new falling edge.
    assign w_fall     = (r_settle == 2'd3) && r_rx_prev && !w_rx_s;

    // Two-flop synchronizer, edge history and post-reset settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_settle  <= 2'd0;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    // Receive FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_push  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_push  <= w_push_next;
        end
    end

    // Receive FSM next-state logic: sample at counter expiry, LSB first
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_push_next  = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                    w_cnt_next   = HALF_BIT;
                end
            end
            S_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else if (!w_rx_s) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = FULL_BIT;
                    w_bit_next   = 3'd0;
                end else begin
                    w_state_next = S_IDLE;  // glitch: line went back high
                end
            end
            S_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else begin
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    w_cnt_next   = FULL_BIT;
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else if (w_rx_s) begin
                    w_push_next  = 1'b1;   // r_shift stays put until the next frame's data bits
                    w_state_next = S_IDLE;
                end else begin
                    w_frame_set  = 1'b1;
                    w_state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_full          = (r_count == DEPTH_CNT);
    assign w_pop           = valid_o && ready_i;
    assign w_wr_en         = r_push && (!w_full || w_pop);
    assign w_ovf_set       = r_push && w_full && !w_pop;
    assign w_rd_ptr_next   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_occ_after_pop = r_count - CW'(w_pop);
    assign w_count_next    = w_occ_after_pop + CW'(w_wr_en);

    // Next head byte. If the pop leaves the buffer empty, the head is the
    // incoming byte when one is written this cycle, and 0 when nothing is written.
    always_comb begin
        w_head_next = 8'h00;
        if (w_occ_after_pop == '0) begin
            if (w_wr_en) w_head_next = r_shift;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    // FIFO storage write port (no reset so it can map to RAM)
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
    end

    // FIFO pointers, occupancy and registered head byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= 8'h00;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_frame_set)    r_frame_err <= 1'b1;
            else if (err_clr_i) r_frame_err <= 1'b0;
            if (w_ovf_set)      r_overflow  <= 1'b1;
            else if (err_clr_i) r_overflow  <= 1'b0;
        end
    end

    assign data_o      = r_head;
    assign valid_o     = (r_count != '0);
    assign busy_o      = (r_state != S_IDLE);
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Testbench for uart_rx_sink. Frames are built bit by bit from the 8N1 rules.
// A queue model of the byte buffer tracks the expected bytes and flags.
module tb_uart_rx_sink;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o, busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // monitor results
    logic [7:0] got_q[$];
    int         valid_cycles = 0;
    int         first_valid_cyc = -1;
    int         stab_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // reference model of the byte buffer and sticky flags
    logic [7:0] model_q[$];
    bit         model_ovf = 0;
    bit         model_ferr = 0;

    uart_rx_sink #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .err_clr_i  (err_clr_i),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record pops, valid cycles and head stability on the falling edge
    always @(negedge clk) begin
        if (valid_o) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_hold && valid_o && data_o !== prev_data) stab_err++;
        if (valid_o && ready_i) got_q.push_back(data_o);
        prev_hold = valid_o && !ready_i;
        prev_data = data_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) model_ferr = 1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
    endtask

    task automatic pulse_clr();
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
    endtask

    // Pulse ready and/or clear in the cycle right after the receiver leaves the stop bit
    task automatic pulse_at_push(input bit do_ready, input bit do_clr, output bit found);
        bit seen_busy;
        seen_busy = 0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (busy_o) seen_busy = 1;
            else if (seen_busy) begin
                found = 1;
                if (do_ready) ready_i = 1'b1;
                if (do_clr) err_clr_i = 1'b1;
                @(posedge clk); #1;
                ready_i = 1'b0;
                err_clr_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        checks++;
        if ({valid_o, busy_o, frame_err_o, overflow_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status: got v/b/fe/ov=%b required 0000", {valid_o, busy_o, frame_err_o, overflow_o});
        end
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %02h required 00", data_o);
        end
        drive_bit(1'b1, 8);
    endtask

    task automatic test_single();
        int t0, lat;
        ready_i = 1'b1;
        got_q.delete();
        valid_cycles = 0;
        first_valid_cyc = -1;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 20);
        lat = first_valid_cyc - t0;
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_data: got %0d bytes first=%02h required 1 byte A5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        checks++;
        if (valid_cycles != 1) begin
            failures++;
            $display("FAIL single_valid_pulse: got %0d valid cycles required 1", valid_cycles);
        end
        checks++;
        if (first_valid_cyc < 0 || lat < 150 || lat > 170) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles required 150..170", lat);
        end
        checks++;
        if ({frame_err_o, overflow_o} !== 2'b00) begin
            failures++;
            $display("FAIL single_flags: got fe/ov=%b required 00", {frame_err_o, overflow_o});
        end
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] b;
        bit done;
        got_q.delete();
        stab_err = 0;
        done = 0;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    b = 8'($urandom);
                    sent.push_back(b);
                    send_frame(b, 1'b1);
                    drive_bit(1'b1, $urandom_range(0, 12));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        ready_i = 1'b1;
        drive_bit(1'b1, 20);
        checks++;
        if (got_q.size() != sent.size()) begin
            failures++;
            $display("FAIL random_count: got %0d bytes required %0d", got_q.size(), sent.size());
        end else begin
            foreach (sent[i]) begin
                checks++;
                if (got_q[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL random_byte%0d: got %02h required %02h", i, got_q[i], sent[i]);
                end
            end
        end
        checks++;
        if (stab_err != 0 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL random_stability: got %0d head changes while stalled, ov=%b; required 0, 0", stab_err, overflow_o);
        end
    endtask

    task automatic test_overflow();
        ready_i = 1'b0;
        model_q.delete();
        model_ovf = 0;
        for (int n = 1; n <= 5; n++) begin
            send_frame(8'(n), 1'b1);
            model_frame(8'(n), 1);
        end
        drive_bit(1'b1, 8);
        checks++;
        if (overflow_o !== model_ovf || valid_o !== 1'b1 || data_o !== model_q[0]) begin
            failures++;
            $display("FAIL overflow_state: got ov=%b v=%b data=%02h required ov=%b v=1 data=%02h",
                     overflow_o, valid_o, data_o, model_ovf, model_q[0]);
        end
        got_q.delete();
        ready_i = 1'b1;
        drive_bit(1'b1, 10);
        ready_i = 1'b0;
        checks++;
        if (got_q.size() != model_q.size()) begin
            failures++;
            $display("FAIL overflow_drain_count: got %0d bytes required %0d", got_q.size(), model_q.size());
        end else begin
            foreach (model_q[i]) begin
                checks++;
                if (got_q[i] !== model_q[i]) begin
                    failures++;
                    $display("FAIL overflow_drain%0d: got %02h required %02h", i, got_q[i], model_q[i]);
                end
            end
        end
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL overflow_empty: got valid=%b required 0", valid_o);
        end
        model_q.delete();
        pulse_clr();
        model_ovf = 0;
        checks++;
        if (overflow_o !== model_ovf) begin
            failures++;
            $display("FAIL overflow_clear: got %b required %b", overflow_o, model_ovf);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        ready_i = 1'b1;
        got_q.delete();
        model_ferr = 0;
        b = 8'($urandom);
        send_frame(b, 1'b0);
        model_frame(b, 0);
        drive_bit(1'b0, 40);
        checks++;
        if (frame_err_o !== model_ferr || busy_o !== 1'b1 || got_q.size() != 0) begin
            failures++;
            $display("FAIL frame_err_state: got fe=%b busy=%b bytes=%0d required fe=%b busy=1 bytes=0",
                     frame_err_o, busy_o, got_q.size(), model_ferr);
        end
        drive_bit(1'b1, 6);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_release: got busy=%b required 0", busy_o);
        end
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C || frame_err_o !== model_ferr) begin
            failures++;
            $display("FAIL frame_err_next_byte: got %0d bytes first=%02h fe=%b required 1 byte 3C fe=%b",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, frame_err_o, model_ferr);
        end
        pulse_clr();
        model_ferr = 0;
        checks++;
        if (frame_err_o !== model_ferr) begin
            failures++;
            $display("FAIL frame_err_clear: got %b required %b", frame_err_o, model_ferr);
        end
    endtask

    task automatic test_glitch();
        ready_i = 1'b1;
        got_q.delete();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        checks++;
        if ({busy_o, valid_o, frame_err_o, overflow_o} !== 4'b0000 || got_q.size() != 0) begin
            failures++;
            $display("FAIL glitch: got b/v/fe/ov=%b bytes=%0d required 0000 bytes=0",
                     {busy_o, valid_o, frame_err_o, overflow_o}, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b1;
        got_q.delete();
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB * 4 + CPB / 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy_o, frame_err_o, overflow_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_state: got b/fe/ov=%b required 000", {busy_o, frame_err_o, overflow_o});
        end
        drive_bit(1'b1, CPB * 4 + 20);
        checks++;
        if (got_q.size() != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_nobyte: got %0d bytes busy=%b required 0 bytes busy=0", got_q.size(), busy_o);
        end
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            failures++;
            $display("FAIL reset_mid_next_byte: got %0d bytes first=%02h required 1 byte 5A",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_low();
        logic [7:0] b;
        ready_i = 1'b1;
        got_q.delete();
        drive_bit(1'b0, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b0, 60);
        checks++;
        if ({busy_o, frame_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_low_no_start: got busy/fe=%b required 00", {busy_o, frame_err_o});
        end
        drive_bit(1'b1, 10);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            failures++;
            $display("FAIL reset_low_next_byte: got %0d bytes first=%02h required 1 byte %02h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        logic [7:0] popped;
        bit found;
        ready_i = 1'b0;
        got_q.delete();
        model_q.delete();
        model_ovf = 0;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1);
        end
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            pulse_at_push(1, 0, found);
        join
        popped = model_q.pop_front();
        model_frame(b, 1);
        checks++;
        if (!found || got_q.size() != 1 || got_q[0] !== popped || overflow_o !== model_ovf) begin
            failures++;
            $display("FAIL full_push_pop: got found=%0d pops=%0d first=%02h ov=%b required found=1 pops=1 first=%02h ov=%b",
                     found, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, overflow_o, popped, model_ovf);
        end
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            pulse_at_push(0, 1, found);
        join
        model_frame(b, 1);
        checks++;
        if (!found || overflow_o !== model_ovf) begin
            failures++;
            $display("FAIL set_beats_clear: got found=%0d ov=%b required found=1 ov=%b", found, overflow_o, model_ovf);
        end
        got_q.delete();
        ready_i = 1'b1;
        drive_bit(1'b1, 10);
        checks++;
        if (got_q.size() != model_q.size()) begin
            failures++;
            $display("FAIL full_drain_count: got %0d bytes required %0d", got_q.size(), model_q.size());
        end else begin
            foreach (model_q[i]) begin
                checks++;
                if (got_q[i] !== model_q[i]) begin
                    failures++;
                    $display("FAIL full_drain%0d: got %02h required %02h", i, got_q[i], model_q[i]);
                end
            end
        end
        model_q.delete();
        pulse_clr();
        model_ovf = 0;
        checks++;
        if (overflow_o !== model_ovf || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_final: got ov=%b v=%b required ov=0 v=0", overflow_o, valid_o);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_random();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_reset_low();
        test_full_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
